// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// loader_pkg : shared FSM states and response codes (CHKSUM exists only with LOADER_CHECKSUM_EN)
// Revision   : 1.0
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_LO  = 3'd1,
    CNT_HI  = 3'd2,
    DATA    = 3'd3,
    RESP    = 3'd4,
    WAIT_TX = 3'd5,
    FINISH  = 3'd6
`ifdef LOADER_CHECKSUM_EN
    , CHKSUM = 3'd7
`endif
  } loader_state_e;

  localparam logic [7:0] LOADER_ACK = 8'hAC;
  localparam logic [7:0] LOADER_NAK = 8'hEE;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// word_assembler : packs strobed bytes little-endian into 32-bit words
// Revision       : 1.0
// ============================================================================
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic        valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (strobe_i) begin
        word_q[{idx_q, 3'b000} +: 8] <= byte_i;
        idx_q                        <= idx_q + 2'd1;
        valid_q                      <= (idx_q == 2'd3);
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : UART-driven IMEM/DMEM loader; LOADER_CHECKSUM_EN adds an XOR checksum stage
// Revision       : 1.0
// ============================================================================
module program_loader #(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              grant_i,
  input  logic              target_i,
  input  logic [7:0]        uart_rx_data_i,
  input  logic              uart_rx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_done_i,
  output logic              done_o,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o
);

  import loader_pkg::*;

  localparam logic [17:0] MAX_W = 18'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e POST_DATA = CHKSUM;
`else
  localparam loader_state_e POST_DATA = RESP;
`endif

  loader_state_e     state_q, state_d;
  logic              target_q;
  logic [15:0]       count_q;
  logic [17:0]       bytes_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        resp_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  logic        rx_w, data_stb_w, last_byte_w, write_w, word_valid_w;
  logic [15:0] count_w;
  logic [31:0] word_w;

  // A strobe arriving with grant low is discarded along with the session.
  assign rx_w        = uart_rx_ready_i && grant_i;
  assign data_stb_w  = rx_w && (state_q == DATA);
  assign last_byte_w = data_stb_w && (bytes_q == ({count_q, 2'b00} - 18'd1));
  assign count_w     = {uart_rx_data_i, count_q[7:0]};
  assign write_w     = word_valid_w && grant_i && (state_q != IDLE);

  word_assembler u_word_assembler (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .byte_i      (uart_rx_data_i),
    .strobe_i    (data_stb_w),
    .clear_i     (state_q == IDLE),
    .word_o      (word_w),
    .word_valid_o(word_valid_w)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // The FSM leaves DATA on the final byte; the matching write lands one cycle later.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && !grant_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (grant_i) state_d = CNT_LO;
        CNT_LO:  if (rx_w) state_d = CNT_HI;
        CNT_HI: begin
          if (rx_w) begin
            if (count_w == 16'd0)                  state_d = POST_DATA;
            else if ({2'b00, count_w} > MAX_W)     state_d = RESP;
            else                                   state_d = DATA;
          end
        end
        DATA:    if (last_byte_w) state_d = POST_DATA;
`ifdef LOADER_CHECKSUM_EN
        CHKSUM:  if (rx_w) state_d = RESP;
`endif
        RESP:    state_d = WAIT_TX;
        WAIT_TX: if (tx_done_i) state_d = FINISH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= 1'b0;
      count_q  <= 16'd0;
      bytes_q  <= 18'd0;
      addr_q   <= '0;
      resp_q   <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_q    <= 8'd0;
`endif
    end else begin
      if (state_q == IDLE && grant_i) begin
        target_q <= target_i;
        count_q  <= 16'd0;
        bytes_q  <= 18'd0;
        addr_q   <= '0;
        resp_q   <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
        chk_q    <= 8'd0;
`endif
      end
      if (rx_w && state_q == CNT_LO) count_q[7:0] <= uart_rx_data_i;
      if (rx_w && state_q == CNT_HI) begin
        count_q[15:8] <= uart_rx_data_i;
        resp_q        <= ({2'b00, count_w} > MAX_W) ? LOADER_NAK : LOADER_ACK;
      end
      if (data_stb_w) begin
        bytes_q <= bytes_q + 18'd1;
`ifdef LOADER_CHECKSUM_EN
        chk_q   <= chk_q ^ uart_rx_data_i;
`endif
      end
      if (write_w) addr_q <= addr_q + ADDR_W'(4);
`ifdef LOADER_CHECKSUM_EN
      if (rx_w && state_q == CHKSUM)
        resp_q <= (uart_rx_data_i == chk_q) ? LOADER_ACK : LOADER_NAK;
`endif
    end
  end

  always_comb begin
    imem_we_o   = write_w && !target_q;
    dmem_we_o   = write_w && target_q;
    tx_start_o  = (state_q == RESP) && grant_i;
    done_o      = (state_q == FINISH) && grant_i;
    tx_data_o   = resp_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = word_w;
  end

endmodule
`default_nettype wire
